// File: rtl/shift_add_mul_pkg.sv
// Shared types, default sizes and the round-robin pick function for the
// shift-and-add multiplier scheduler.
package shift_add_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned M      = 8;
    localparam int unsigned N      = 8;
    localparam int unsigned RR_MAX = 32;

    // First set bit of valid at or after ptr, wrapping at nreq-1; ptr if none set.
    function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] valid,
                                            input int unsigned ptr,
                                            input int unsigned nreq);
        int unsigned idx;
        logic        found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            idx = ptr + k;
            if (idx >= nreq) idx = idx - nreq;
            if (k < nreq && !found && valid[idx[4:0]]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/shift_add_mul_scheduler_arb.sv
// Combinational round-robin arbiter: valid vector and search pointer in,
// one-hot grant and grant index out. The pointer register lives in the scheduler.
module mul_rr_arbiter #(
    parameter  int unsigned NREQ = shift_add_mul_pkg::NREQ,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);
    import shift_add_mul_pkg::*;

    always_comb begin
        idx   = IDW'(rr_pick(RR_MAX'(valid), 32'(ptr), NREQ));
        grant = (|valid) ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/shift_add_mul_scheduler.sv
// Round-robin shared iterative shift-and-add multiplier, one multiplier bit per clock.
// Define EARLY_TERM_EN to leave RUN as soon as no set multiplier bits remain.
module shift_add_mul_scheduler #(
    parameter  int unsigned NREQ = shift_add_mul_pkg::NREQ,
    parameter  int unsigned M    = shift_add_mul_pkg::M,
    parameter  int unsigned N    = shift_add_mul_pkg::N,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*M-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [M+N-1:0]    rsp_p,
    output logic              busy
);
    import shift_add_mul_pkg::*;

    localparam int unsigned PW = M + N;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    state_t          state, state_nxt;
    logic [PW-1:0]   a_sh, acc, acc_nxt;
    logic [N-1:0]    b_sh;
    logic [CW-1:0]   cnt;
    logic [IDW-1:0]  rr_ptr, g_idx;
    logic [NREQ-1:0] g_onehot;
    logic            grant_any, last;

    mul_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (g_onehot),
        .idx   (g_idx)
    );

    assign grant_any = |g_onehot;
    assign acc_nxt   = b_sh[0] ? acc + a_sh : acc;
`ifdef EARLY_TERM_EN
    // Remaining multiplier bits after this cycle's shift are all zero.
    assign last = (cnt == CW'(N - 1)) || (b_sh[N-1:1] == '0);
`else
    assign last = (cnt == CW'(N - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                req_ready = g_onehot;
                if (grant_any) state_nxt = RUN;
            end
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            cnt    <= '0;
            rr_ptr <= '0;
            rsp_id <= '0;
            rsp_p  <= '0;
        end else begin
            case (state)
                IDLE: if (grant_any) begin
                    a_sh   <= PW'(req_a[g_idx*M +: M]);
                    b_sh   <= req_b[g_idx*N +: N];
                    acc    <= '0;
                    cnt    <= '0;
                    rsp_id <= g_idx;
                    rr_ptr <= (g_idx == IDW'(NREQ - 1)) ? '0 : g_idx + 1'b1;
                end
                RUN: begin
                    acc  <= acc_nxt;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (last) rsp_p <= acc_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mul_scheduler.sv
// Self-checking bench for shift_add_mul_scheduler: vector table, round-robin,
// backpressure and mid-job reset sequences with a product scoreboard.
module tb_shift_add_mul_scheduler;

    localparam int unsigned NREQ = 4;
    localparam int unsigned M    = 8;
    localparam int unsigned N    = 8;
    localparam int unsigned IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*M-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic              rsp_valid, rsp_ready, busy;
    logic [IDW-1:0]    rsp_id;
    logic [M+N-1:0]    rsp_p;

    typedef struct {
        int unsigned id;
        int unsigned p;
    } exp_t;

    typedef struct {
        int unsigned idx;
        int unsigned a;
        int unsigned b;
        int unsigned p;
        int unsigned lat_fix;
        int unsigned lat_early;
    } vec_t;

    int unsigned tests = 0;
    int unsigned fails = 0;
    exp_t        sb[$];
    int unsigned grants[$];
    bit          auto_push = 1'b0;

    always #5 clk = ~clk;

    shift_add_mul_scheduler #(.NREQ(NREQ), .M(M), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .busy      (busy)
    );

    task automatic check(input string name, input int unsigned got, input int unsigned exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Grant legality every cycle; scoreboard push on grant (when enabled), pop on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            if (!$onehot0(req_ready) || (busy && req_ready != '0)) begin
                fails++;
                $display("FAIL req_ready_legal: got %b with busy=%0b, expected one-hot/zero and zero when busy",
                         req_ready, busy);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    exp_t e;
                    grants.push_back(i);
                    e.id = i;
                    e.p  = 32'(req_a[i*M +: M]) * 32'(req_b[i*N +: N]);
                    if (auto_push) sb.push_back(e);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp_unexpected: got id %0d p %0d, expected no response", rsp_id, rsp_p);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_id", rsp_id, e.id);
                    check("rsp_p", rsp_p, e.p);
                end
            end
        end
    end

    // Latency is counted from the cycle in which req_ready is seen high.
    task automatic run_one(input int unsigned k, input int unsigned idx, input int unsigned a,
                           input int unsigned b, input int unsigned p, input int unsigned lat);
        int unsigned cyc;
        bit          got;
        exp_t        e;
        @(posedge clk); #1;
        req_a[idx*M +: M] = M'(a);
        req_b[idx*N +: N] = N'(b);
        req_valid[idx]    = 1'b1;
        got = 1'b0; cyc = 0;
        while (!got && cyc < 50) begin
            @(negedge clk);
            if (req_ready[idx]) got = 1'b1; else cyc++;
        end
        check($sformatf("v%0d_grant", k), 32'(got), 1);
        e.id = idx;
        e.p  = p;
        if (got) sb.push_back(e);
        @(posedge clk); #1;
        req_valid[idx]    = 1'b0;
        req_a[idx*M +: M] = ~M'(a);
        req_b[idx*N +: N] = ~N'(b);
        got = 1'b0; cyc = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) got = 1'b1;
        end
        check($sformatf("v%0d_latency", k), got ? cyc : 0, lat);
        cyc = 0;
        while (busy && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("v%0d_idle", k), 32'(busy), 0);
    endtask

    initial begin
        vec_t            vecs[9];
        int unsigned     cyc;
        bit              got;
        logic [NREQ-1:0] gid;

        vecs[0] = '{0,  13,  11,   143, 9, 5};
        vecs[1] = '{1, 255, 255, 65025, 9, 9};
        vecs[2] = '{2,   0, 200,     0, 9, 9};
        vecs[3] = '{3,  77,   0,     0, 9, 2};
        vecs[4] = '{0, 200,   1,   200, 9, 2};
        vecs[5] = '{1,   3, 128,   384, 9, 9};
        vecs[6] = '{2, 100,  37,  3700, 9, 7};
        vecs[7] = '{3,   1,   6,     6, 9, 4};
        vecs[8] = '{1, 170,  85, 14450, 9, 8};

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_rsp_p", 32'(rsp_p), 0);
        check("reset_rsp_id", 32'(rsp_id), 0);
        check("reset_req_ready", 32'(req_ready), 0);
        rst = 1'b0;

        for (int k = 0; k < 9; k++) begin
`ifdef EARLY_TERM_EN
            run_one(k, vecs[k].idx, vecs[k].a, vecs[k].b, vecs[k].p, vecs[k].lat_early);
`else
            run_one(k, vecs[k].idx, vecs[k].a, vecs[k].b, vecs[k].p, vecs[k].lat_fix);
`endif
        end

        // All four requesters valid from a fresh pointer.
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        grants.delete();
        auto_push = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*M +: M] = M'(10 + i * 20);
            req_b[i*N +: N] = N'(3 + i * 50);
        end
        req_valid = '1;
        cyc = 0;
        while (grants.size() < 5 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk); #1; req_valid = '0;
        cyc = 0;
        while ((busy || sb.size() != 0) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("rr_count", grants.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < grants.size()) check($sformatf("rr_order%0d", k), grants[k], k % 4);
        check("rr_drain", sb.size(), 0);

        // Backpressure: pointer is now 1, requesters 1 and 3 valid.
        grants.delete();
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_a[1*M +: M] = 8'd201; req_b[1*N +: N] = 8'd99;
        req_a[3*M +: M] = 8'd17;  req_b[3*N +: N] = 8'd250;
        req_valid = 4'b1010;
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("bp_first_grant", grants.size() > 0 ? grants[0] : 99, 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_id", 32'(rsp_id), 1);
            check("bp_p", 32'(rsp_p), 19899);
            check("bp_no_ready", 32'(req_ready), 0);
        end
        @(posedge clk); #1; rsp_ready = 1'b1;
        got = 1'b0; cyc = 0; gid = '0;
        while (!got && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (req_ready != '0) begin got = 1'b1; gid = req_ready; end
        end
        check("bp_next_grant", 32'(gid), 32'b1000);
        check("bp_grant_delay", cyc, 2);
        @(posedge clk); #1; req_valid = '0;
        cyc = 0;
        while ((busy || sb.size() != 0) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("bp_drain", sb.size(), 0);

        // Reset in the middle of RUN; the discarded job leaves no response.
        auto_push = 1'b0;
        @(posedge clk); #1;
        req_a[2*M +: M] = 8'd50; req_b[2*N +: N] = 8'd60;
        req_valid = 4'b0100;
        got = 1'b0; cyc = 0;
        while (!got && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (req_ready[2]) got = 1'b1;
        end
        check("mr_grant", 32'(got), 1);
        @(posedge clk); #1; req_valid = '0;
        repeat (3) @(posedge clk);
        #3; rst = 1'b1;
        #1;
        check("mr_busy", 32'(busy), 0);
        check("mr_rsp_valid", 32'(rsp_valid), 0);
        check("mr_rsp_p", 32'(rsp_p), 0);
        check("mr_rsp_id", 32'(rsp_id), 0);
        @(posedge clk); #1; rst = 1'b0;
        auto_push = 1'b1;
        req_a[3*M +: M] = 8'd9; req_b[3*N +: N] = 8'd9;
        req_valid = 4'b1100;
        got = 1'b0; cyc = 0; gid = '0;
        while (!got && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (req_ready != '0) begin got = 1'b1; gid = req_ready; end
        end
        check("mr_first_grant", 32'(gid), 32'b0100);
        @(posedge clk); #1; req_valid[2] = 1'b0;
        got = 1'b0; cyc = 0; gid = '0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (req_ready != '0) begin got = 1'b1; gid = req_ready; end
        end
        check("mr_second_grant", 32'(gid), 32'b1000);
        @(posedge clk); #1; req_valid = '0;
        cyc = 0;
        while ((busy || sb.size() != 0) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("final_sb_empty", sb.size(), 0);
        check("final_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
        $fatal(1);
    end

endmodule
